muldiv_unit: RTL

- Iterative RV32M/RV64M multiply/divide execution unit. It sits beside the ALU in the EX stage of the 5-stage pipeline.
- On start it captures the operands and iterates, holding the pipeline via busy, then presents one result with a single-cycle done pulse.
- It is parametrised in datapath width and bits retired per cycle. It adds divide-by-zero/overflow fast paths and flush abort, which the single-cycle ALU path does not have.

---
 rtl/muldiv_unit_if.sv | 23 ++
 rtl/muldiv_unit.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the EX stage and the iterative multiply/divide unit.
interface muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1Data;
  logic [XLEN-1:0] rs2Data;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, rs1Data, rs2Data, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, rs1Data, rs2Data, flush,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide: shift-add multiply, restoring divide,
// BITS_PER_CYCLE bits per iteration, with divide-by-zero/overflow fast paths.
module muldiv_unit #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input logic          clk,
  input logic          reset,
  muldiv_unit_if.slave bus
);
  localparam int unsigned NITER = XLEN / BITS_PER_CYCLE;
  localparam int unsigned CW    = $clog2(NITER + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [2:0]        op_q, op_d;
  logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d;

  logic              sgn_a, sgn_b, in_neg_a, in_neg_b, div_zero, div_ovf;
  logic [XLEN-1:0]   mag_a, mag_b, fast_res, quo_fix, rem_fix, calc_res;
  logic [2*XLEN-1:0] step_acc, prod_fix;

  always_comb begin : decode
    sgn_a    = bus.funct3 inside {3'd1, 3'd2, 3'd4, 3'd6};
    sgn_b    = bus.funct3 inside {3'd1, 3'd4, 3'd6};
    in_neg_a = sgn_a & bus.rs1Data[XLEN-1];
    in_neg_b = sgn_b & bus.rs2Data[XLEN-1];
    mag_a    = in_neg_a ? -bus.rs1Data : bus.rs1Data;
    mag_b    = in_neg_b ? -bus.rs2Data : bus.rs2Data;
    div_zero = bus.funct3[2] && (bus.rs2Data == '0);
    div_ovf  = bus.funct3[2] && !bus.funct3[0] &&
               (bus.rs1Data == MIN_NEG) && (bus.rs2Data == '1);
    if (bus.funct3[1]) fast_res = div_zero ? bus.rs1Data : '0;
    else               fast_res = div_zero ? '1 : bus.rs1Data;
  end

  // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide.
  always_comb begin : iterate
    logic [XLEN:0] part;
    step_acc = acc_q;
    part     = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (op_q[2]) begin
        part = {step_acc[2*XLEN-1:XLEN], step_acc[XLEN-1]} - {1'b0, opnd_q};
        if (part[XLEN]) step_acc = {step_acc[2*XLEN-2:0], 1'b0};
        else            step_acc = {part[XLEN-1:0], step_acc[XLEN-2:0], 1'b1};
      end else begin
        part     = {1'b0, step_acc[2*XLEN-1:XLEN]} + (step_acc[0] ? {1'b0, opnd_q} : '0);
        step_acc = {part, step_acc[XLEN-1:1]};
      end
    end
  end

  always_comb begin : finalize
    prod_fix = (neg_a_q ^ neg_b_q) ? -step_acc : step_acc;
    quo_fix  = (neg_a_q ^ neg_b_q) ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
    rem_fix  = neg_a_q ? -step_acc[2*XLEN-1:XLEN] : step_acc[2*XLEN-1:XLEN];
    case (op_q)
      3'd0:                calc_res = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    calc_res = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:          calc_res = quo_fix;
      default:             calc_res = rem_fix;
    endcase
  end

  always_comb begin : fsm
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    op_d     = op_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          op_d    = bus.funct3;
          neg_a_d = in_neg_a;
          neg_b_d = in_neg_b;
          if (bus.funct3[2]) begin
            acc_d  = {{XLEN{1'b0}}, mag_a};
            opnd_d = mag_b;
          end else begin
            acc_d  = {{XLEN{1'b0}}, mag_b};
            opnd_d = mag_a;
          end
          if (div_zero || div_ovf) begin
            result_d = fast_res;
            cnt_d    = '0;
            state_d  = DONE;
          end else begin
            cnt_d   = CW'(NITER);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (bus.flush) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            result_d = calc_res;
            state_d  = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      op_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
      op_q     <= op_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
    end
  end

  assign bus.busy   = (state_q == CALC);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
endmodule
